clock_meter: RTL
================

CLOCK_METER -- requires

Module: clock_meter

Interface
- REQ-001 Parameter CNT_W, default 16: width of the period and high-time counters and results.
- REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sig_in; legal range 2..4.
- REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
- REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
- REQ-005 sig_in  input  1  slow signal to be measured (e.g. a divided clock), asynchronous to clk.
- REQ-006 start  input  1  single-cycle request to begin a measurement.
- REQ-007 ack  input  1  consumer acknowledge of a presented result.
- REQ-008 busy  output  1  high while a measurement is in progress.
- REQ-009 valid  output  1  result registers hold a completed measurement.
- REQ-010 period  output  CNT_W  clk cycles between two consecutive rising edges of sig_in.
- REQ-011 high_time  output  CNT_W  clk cycles from that rising edge to the following falling edge.
- REQ-012 overflow  output  1  measurement timed out before completion.

Function
- REQ-013 sig_in shall pass through SYNC_STAGES flops; rise/fall strobes shall come from comparing the last sync stage with one further registered copy.
- REQ-014 The FSM shall have states IDLE, WAIT_RISE, MEASURE and DONE; busy shall be high exactly in WAIT_RISE and MEASURE.
- REQ-015 In IDLE or DONE, start=1 shall clear valid and overflow, clear the counter and enter WAIT_RISE on the next edge; start has priority over ack.
- REQ-016 start in WAIT_RISE or MEASURE shall be ignored.
- REQ-017 In WAIT_RISE, a rise strobe shall clear the counter and enter MEASURE; otherwise the counter increments.
- REQ-018 In MEASURE, the counter shall increment every cycle; the first fall strobe shall load high_time with counter+1.
- REQ-019 In MEASURE, a rise strobe shall load period with counter+1, set valid and enter DONE.
- REQ-020 The period and high_time values shall therefore equal true sig_in cycle counts; e.g. 8-cycle period, 50 % duty -> period=8, high_time=4.
- REQ-021 If the counter reaches 2^CNT_W-1 in WAIT_RISE, the block shall enter DONE with overflow=1, valid=1, period=0 and high_time=0.
- REQ-022 If the counter reaches 2^CNT_W-1 in MEASURE, the block shall enter DONE with overflow=1, valid=1 and period=2^CNT_W-1, keeping high_time if it was already captured, else 2^CNT_W-1.
- REQ-023 In DONE, outputs shall hold; ack=1 without start shall clear valid on the next edge and return to IDLE.
- REQ-024 ack outside DONE shall be ignored.
- REQ-025 A rise and fall strobe can never occur in the same cycle; no special handling is required.

Reset
- REQ-026 reset shall force IDLE, busy=0, valid=0, overflow=0, period=0, high_time=0, counter=0 and all synchronizer/edge flops to 0.
- REQ-027 reset asserted mid-measurement shall abort it with no result; start is required after release.

Configuration
- REQ-028 With CLOCK_METER_GLITCH_FILTER_EN defined, a level change on the synchronized signal shall only be accepted after it is stable for 2 consecutive cycles; single-cycle pulses shall produce no strobe. Strobe latency grows by 1 cycle, and period/high_time for clean inputs shall be unchanged.
- REQ-029 Without CLOCK_METER_GLITCH_FILTER_EN, every synchronized level change shall produce a strobe.

Verification
- REQ-030 sig_in period 8, high 4, start pulse -> valid with period=8, high_time=4, overflow=0; ack -> valid=0 next cycle, state IDLE.
- REQ-031 sig_in period 10, high 3 -> period=10, high_time=3.
- REQ-032 CNT_W=8, sig_in held low, start -> after 255 cycles valid=1, overflow=1, period=0.
- REQ-033 start pulses during MEASURE -> ignored; the result matches the undisturbed run.
- REQ-034 reset asserted during MEASURE -> all outputs 0 immediately; no valid until a new start.
- REQ-035 Macro defined, 1-cycle glitch high inside the low phase of a period-16 signal -> period=16; without the macro -> the glitch is measured as an edge.

Source files
------------

// File: rtl/clock_meter.sv
// clock_meter: measures the period and high time of a slow asynchronous
// signal (sig_in) in clk cycles. A start request arms the meter. It waits for
// a rising edge, times the following high phase and full period, then holds
// the result until it is acknowledged.
//
// Optional build macro: CLOCK_METER_GLITCH_FILTER_EN
//    A level change on the synchronized signal is accepted only once it has
//    been stable for two consecutive cycles. Single-cycle pulses are dropped.
//    The edge strobes then come one cycle later than in the default build.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no measurement running; result (if any) already acknowledged
// WAIT_RISE | armed, counting toward timeout while waiting for a rising edge
// MEASURE   | counting from the rising edge; high time on first fall,
//           | period on the next rise
// DONE      | result held (valid=1) until ack or a new start

module clock_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   input  logic             ack,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   sig_dly;
   logic                   sig_last;
   logic                   rise;
   logic                   fall;
   logic [CNT_W-1:0]       cnt;
   logic                   high_got;

   assign sig_last = sync[SYNC_STAGES-1];

   // synchronizer chain plus one extra registered copy for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync    <= '0;
         sig_dly <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], sig_in};
         sig_dly <= sig_last;
      end
   end

`ifdef CLOCK_METER_GLITCH_FILTER_EN
   logic lvl;

   // accepted level follows the synchronized signal only after two equal samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lvl <= 1'b0;
      else if (sig_last == sig_dly)
         lvl <= sig_last;
   end

   assign rise =  sig_last &  sig_dly & ~lvl;
   assign fall = ~sig_last & ~sig_dly &  lvl;
`else
   assign rise =  sig_last & ~sig_dly;
   assign fall = ~sig_last &  sig_dly;
`endif

   // measurement sequencer; all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         period    <= '0;
         high_time <= '0;
         cnt       <= '0;
         high_got  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= WAIT_RISE;
                  busy     <= 1'b1;
                  valid    <= 1'b0;
                  overflow <= 1'b0;
                  cnt      <= '0;
               end else if (state == DONE && ack) begin
                  state <= IDLE;
                  valid <= 1'b0;
               end
            end
            WAIT_RISE: begin
               if (rise) begin
                  state    <= MEASURE;
                  cnt      <= '0;
                  high_got <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  // counter reaches its maximum on this edge: no edge seen at all
                  state     <= DONE;
                  cnt       <= CNT_MAX;
                  busy      <= 1'b0;
                  valid     <= 1'b1;
                  overflow  <= 1'b1;
                  period    <= '0;
                  high_time <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  valid  <= 1'b1;
                  period <= cnt + CNT_ONE;
               end else if (cnt == CNT_LAST) begin
                  state    <= DONE;
                  cnt      <= CNT_MAX;
                  busy     <= 1'b0;
                  valid    <= 1'b1;
                  overflow <= 1'b1;
                  period   <= CNT_MAX;
                  if (!high_got)
                     high_time <= CNT_MAX;
               end else begin
                  cnt <= cnt + CNT_ONE;
                  if (fall && !high_got) begin
                     high_time <= cnt + CNT_ONE;
                     high_got  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
